rd_word_uart_tx: RTL and testbench

Downstream consumer of one channel's RD / RdAdr pair from the read-address sequencer. On each RD pulse it captures the word read from the channel buffer RAM at RdAdr into a 2-deep FIFO. It serialises each word as a UART frame: start bit, DATA_W data bits LSB-first, optional even parity, stop bit. It flags the last word of each 18-word block with a one-cycle frame_done pulse. One instance is used per channel (five total).

---
 rtl/rd_word_uart_tx.sv | 221 ++++++++++++++++++++++
 tb/tb_rd_word_uart_tx.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/rd_word_uart_tx.sv
// Per-channel RAM word capture on RD strobes, 2-deep FIFO, and UART serialiser
// (start, LSB-first data, optional even parity, stop) with end-of-block pulse.
module rd_word_uart_tx #(
    parameter int DATA_W          = 8,
    parameter int CLKS_PER_BIT    = 6,
    parameter int RD_LAT          = 2,
    parameter int WORDS_PER_FRAME = 18,
    parameter int PARITY_EN       = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rd,
    input  logic [4:0]        rd_adr,
    input  logic [DATA_W-1:0] ram_q,
    output logic              tx,
    output logic              busy,
    output logic              frame_done,
    output logic              overrun,
    input  logic              clr_ovr
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam int LW = $clog2(RD_LAT + 1);

    localparam logic [CW-1:0] CLK_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_W - 1);
    localparam logic [LW-1:0] LAT_LAST = LW'(RD_LAT);
    localparam logic [4:0]    LAST_ADR = 5'(WORDS_PER_FRAME - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    // ------------------------------------------------------------------
    // RD edge detect and RAM-latency capture pipeline
    // ------------------------------------------------------------------
    logic          rd_d;
    logic          rise;
    logic          pend;
    logic [LW-1:0] lat_cnt;
    logic [4:0]    adr_q;
    logic          cap;

    assign rise = rd & ~rd_d;
    // A rise in the capture cycle restarts the delay, so that capture is lost.
    assign cap  = pend & (lat_cnt == LAT_LAST) & ~rise;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_d    <= 1'b0;
            pend    <= 1'b0;
            lat_cnt <= '0;
            adr_q   <= '0;
        end else begin
            rd_d <= rd;
            if (rise) begin
                pend    <= 1'b1;
                lat_cnt <= LW'(1);
                adr_q   <= rd_adr;
            end else if (cap) begin
                pend    <= 1'b0;
                lat_cnt <= '0;
            end else if (pend) begin
                lat_cnt <= lat_cnt + LW'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // 2-entry FIFO of {last, data}
    // ------------------------------------------------------------------
    logic [DATA_W:0] mem [2];
    logic            wr_ptr;
    logic            rd_ptr;
    logic [1:0]      cnt;
    logic            full;
    logic            push_ok;
    logic            ovr_set;
    logic            pop;
    logic [DATA_W:0] head;

    assign full    = (cnt == 2'd2);
    assign push_ok = cap & ~full;
    assign ovr_set = cap & full;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem[0]  <= '0;
            mem[1]  <= '0;
            wr_ptr  <= 1'b0;
            rd_ptr  <= 1'b0;
            cnt     <= 2'd0;
            overrun <= 1'b0;
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= {(adr_q == LAST_ADR), ram_q};
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push_ok, pop})
                2'b10:   cnt <= cnt + 2'd1;
                2'b01:   cnt <= cnt - 2'd1;
                default: cnt <= cnt;
            endcase
            // A fresh overrun wins over a simultaneous clear.
            overrun <= (overrun & ~clr_ovr) | ovr_set;
        end
    end

    // ------------------------------------------------------------------
    // TX FSM
    // ------------------------------------------------------------------
    state_t            state, state_n;
    logic [CW-1:0]     clk_cnt, clk_cnt_n;
    logic [BW-1:0]     bit_cnt, bit_cnt_n;
    logic [DATA_W-1:0] shift, shift_n;
    logic              last_q, last_n;
    logic              par_q, par_n;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= S_IDLE;
            clk_cnt <= '0;
            bit_cnt <= '0;
            shift   <= '0;
            last_q  <= 1'b0;
            par_q   <= 1'b0;
        end else begin
            state   <= state_n;
            clk_cnt <= clk_cnt_n;
            bit_cnt <= bit_cnt_n;
            shift   <= shift_n;
            last_q  <= last_n;
            par_q   <= par_n;
        end
    end

    always_comb begin
        state_n    = state;
        clk_cnt_n  = clk_cnt;
        bit_cnt_n  = bit_cnt;
        shift_n    = shift;
        last_n     = last_q;
        par_n      = par_q;
        pop        = 1'b0;
        tx         = 1'b1;
        frame_done = 1'b0;

        case (state)
            S_IDLE: begin
                tx = 1'b1;
                if (cnt != 2'd0) begin
                    pop       = 1'b1;
                    shift_n   = head[DATA_W-1:0];
                    last_n    = head[DATA_W];
                    par_n     = ^head[DATA_W-1:0];
                    clk_cnt_n = '0;
                    bit_cnt_n = '0;
                    state_n   = S_START;
                end
            end
            S_START: begin
                tx = 1'b0;
                if (clk_cnt == CLK_LAST) begin
                    clk_cnt_n = '0;
                    state_n   = S_DATA;
                end else begin
                    clk_cnt_n = clk_cnt + CW'(1);
                end
            end
            S_DATA: begin
                tx = shift[0];
                if (clk_cnt == CLK_LAST) begin
                    clk_cnt_n = '0;
                    shift_n   = shift >> 1;
                    if (bit_cnt == BIT_LAST) begin
                        bit_cnt_n = '0;
                        state_n   = (PARITY_EN != 0) ? S_PARITY : S_STOP;
                    end else begin
                        bit_cnt_n = bit_cnt + BW'(1);
                    end
                end else begin
                    clk_cnt_n = clk_cnt + CW'(1);
                end
            end
            S_PARITY: begin
                tx = par_q;
                if (clk_cnt == CLK_LAST) begin
                    clk_cnt_n = '0;
                    state_n   = S_STOP;
                end else begin
                    clk_cnt_n = clk_cnt + CW'(1);
                end
            end
            S_STOP: begin
                tx = 1'b1;
                if (clk_cnt == CLK_LAST) begin
                    clk_cnt_n  = '0;
                    frame_done = last_q;
                    state_n    = S_IDLE;
                end else begin
                    clk_cnt_n = clk_cnt + CW'(1);
                end
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    assign busy = (state != S_IDLE) | (cnt != 2'd0);

endmodule

// File: tb/tb_rd_word_uart_tx.sv
// Bench for rd_word_uart_tx: a plain instance and an even-parity instance share
// stimulus; per-instance UART monitors decode tx and check against expected queues.
module tb_rd_word_uart_tx;

    localparam int W   = 8;
    localparam int CPB = 6;
    localparam int LAT = 2;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         rd = 1'b0;
    logic [4:0]   rd_adr = 5'd0;
    logic [W-1:0] ram_q = '0;
    logic         clr_ovr = 1'b0;

    logic tx, busy, frame_done, overrun;
    logic tx_p, busy_p, frame_done_p, overrun_p;

    rd_word_uart_tx #(.DATA_W(W), .CLKS_PER_BIT(CPB), .RD_LAT(LAT),
                      .WORDS_PER_FRAME(18), .PARITY_EN(0)) dut (
        .clk(clk), .rst(rst), .rd(rd), .rd_adr(rd_adr), .ram_q(ram_q),
        .tx(tx), .busy(busy), .frame_done(frame_done), .overrun(overrun),
        .clr_ovr(clr_ovr)
    );

    rd_word_uart_tx #(.DATA_W(W), .CLKS_PER_BIT(CPB), .RD_LAT(LAT),
                      .WORDS_PER_FRAME(18), .PARITY_EN(1)) dut_p (
        .clk(clk), .rst(rst), .rd(rd), .rd_adr(rd_adr), .ram_q(ram_q),
        .tx(tx_p), .busy(busy_p), .frame_done(frame_done_p), .overrun(overrun_p),
        .clr_ovr(clr_ovr)
    );

    // ---------------- clock / reset bookkeeping ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int rst_events = 0;
    always @(negedge rst) rst_events++;

    int fd_cnt = 0, fd_cnt_p = 0;
    always @(negedge clk) begin
        if (frame_done)   fd_cnt++;
        if (frame_done_p) fd_cnt_p++;
    end

    // ---------------- scoreboard ----------------
    // entry = {parity, last, data}
    logic [W+1:0] exp_q[$];
    logic [W+1:0] exp_pq[$];
    int passed = 0, total = 0;
    int frames = 0, frames_p = 0;
    int mon_start_cyc = 0;
    int rise_cyc = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        else passed++;
    endtask

    function automatic logic sel_tx(input bit p);
        return p ? tx_p : tx;
    endfunction

    function automatic logic sel_fd(input bit p);
        return p ? frame_done_p : frame_done;
    endfunction

    // Samples each bit mid-cell; discards frames cut by a reset.
    task automatic monitor(input bit p);
        logic [W-1:0] d;
        logic         sb, pb, stb, fd;
        logic [W+1:0] e;
        int           r0, sc;
        forever begin
            do @(negedge clk); while (!(rst && sel_tx(p) == 1'b0));
            sc = cyc;
            r0 = rst_events;
            pb = 1'b0;
            repeat (CPB / 2) @(negedge clk);
            sb = sel_tx(p);
            for (int i = 0; i < W; i++) begin
                repeat (CPB) @(negedge clk);
                d[i] = sel_tx(p);
            end
            if (p) begin
                repeat (CPB) @(negedge clk);
                pb = sel_tx(p);
            end
            repeat (CPB) @(negedge clk);
            stb = sel_tx(p);
            repeat (CPB - CPB / 2 - 1) @(negedge clk);
            fd = sel_fd(p);
            if (rst_events == r0 && rst) begin
                if (p) frames_p++; else begin frames++; mon_start_cyc = sc; end
                if ((p ? exp_pq.size() : exp_q.size()) == 0) begin
                    check(p ? "unexpected_frame_p" : "unexpected_frame", 32'(d), 32'hFFFF_FFFF);
                end else begin
                    e = p ? exp_pq.pop_front() : exp_q.pop_front();
                    check(p ? "start_bit_p" : "start_bit", 32'(sb), 32'd0);
                    check(p ? "data_p" : "data", 32'(d), 32'(e[W-1:0]));
                    check(p ? "stop_bit_p" : "stop_bit", 32'(stb), 32'd1);
                    check(p ? "frame_done_p" : "frame_done", 32'(fd), 32'(e[W]));
                    if (p) check("parity_bit", 32'(pb), 32'(e[W+1]));
                end
            end
        end
    endtask

    initial monitor(1'b0);
    initial monitor(1'b1);

    // ---------------- driver tasks ----------------
    task automatic send(input logic [4:0] adr, input logic [W-1:0] data, input int width,
                        input bit expect_frame, input logic parity);
        logic [W+1:0] e;
        @(negedge clk);
        if (expect_frame) begin
            e = {parity, (adr == 5'd17), data};
            exp_q.push_back({1'b0, e[W:0]});
            exp_pq.push_back(e);
        end
        rd       = 1'b1;
        rd_adr   = adr;
        ram_q    = data;
        rise_cyc = cyc;
        repeat (width) @(negedge clk);
        rd = 1'b0;
    endtask

    task automatic wait_idle(input int max);
        int n = 0;
        repeat (LAT + 3) @(negedge clk);
        while ((busy || busy_p) && n < max) begin
            @(negedge clk);
            n++;
        end
        check("idle_timeout", 32'(n < max), 32'd1);
        repeat (5) @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $display("%0d/%0d checks passed", passed, total);
        $fatal(1, "watchdog");
    end

    // ---------------- directed stimulus ----------------
    initial begin
        int fsnap;
        @(negedge clk);
        check("rst_tx", 32'(tx), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_frame_done", 32'(frame_done), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);

        // single word 0xA5, 4-cycle pulse
        send(5'd3, 8'hA5, 4, 1'b1, 1'b0);
        wait_idle(400);
        check("start_latency", 32'(mon_start_cyc - rise_cyc), 32'(LAT + 2));
        check("single_fd_none", 32'(fd_cnt), 32'd0);

        // full 18-word block, 65-cycle spacing
        for (int a = 0; a < 18; a++) begin
            logic [W-1:0] v;
            v = 8'h10 + 8'(a);
            send(5'(a), v, 1, 1'b1, ^v);
            repeat (64) @(negedge clk);
        end
        wait_idle(400);
        check("block_fd_count", 32'(fd_cnt), 32'd1);
        check("block_fd_count_p", 32'(fd_cnt_p), 32'd1);
        check("block_overrun", 32'(overrun), 32'd0);
        check("block_overrun_p", 32'(overrun_p), 32'd0);

        // overrun: 4 pulses 3 cycles apart, 4th dropped
        send(5'd1, 8'h31, 1, 1'b1, 1'b1);
        repeat (2) @(negedge clk);
        send(5'd2, 8'h32, 1, 1'b1, 1'b1);
        repeat (2) @(negedge clk);
        send(5'd3, 8'h33, 1, 1'b1, 1'b0);
        repeat (2) @(negedge clk);
        send(5'd4, 8'h34, 1, 1'b0, 1'b1);
        repeat (5) @(negedge clk);
        check("overrun_set", 32'(overrun), 32'd1);
        check("overrun_set_p", 32'(overrun_p), 32'd1);
        clr_ovr = 1'b1;
        @(negedge clk);
        clr_ovr = 1'b0;
        check("overrun_clr", 32'(overrun), 32'd0);
        check("overrun_clr_p", 32'(overrun_p), 32'd0);
        wait_idle(600);

        // held strobe: 20 cycles high, one capture
        fsnap = frames;
        send(5'd6, 8'h5C, 20, 1'b1, 1'b0);
        wait_idle(400);
        check("held_one_frame", 32'(frames - fsnap), 32'd1);

        // parity words
        send(5'd7, 8'h07, 1, 1'b1, 1'b1);
        wait_idle(400);
        send(5'd8, 8'h03, 1, 1'b1, 1'b0);
        wait_idle(400);

        // reset during DATA bit 3
        send(5'd5, 8'h96, 1, 1'b0, 1'b0);
        repeat (29) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check("midrst_tx", 32'(tx), 32'd1);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_tx_p", 32'(tx_p), 32'd1);
        check("midrst_busy_p", 32'(busy_p), 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        fsnap = frames;
        repeat (120) @(negedge clk);
        check("midrst_no_residual", 32'(frames - fsnap), 32'd0);
        check("midrst_idle_tx", 32'(tx), 32'd1);
        send(5'd9, 8'h3C, 1, 1'b1, 1'b0);
        wait_idle(400);
        check("post_rst_frame", 32'(frames - fsnap), 32'd1);

        check("exp_q_empty", 32'(exp_q.size()), 32'd0);
        check("exp_pq_empty", 32'(exp_pq.size()), 32'd0);
        check("final_fd_count", 32'(fd_cnt), 32'd1);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
